// File: rtl/fcmp_unit.sv
// rtl/fcmp_unit.sv - two-stage pipelined single-precision FEQ/FLT/FLE compare unit
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   flush            kills every in-flight request and blocks a same-cycle accept
//   in_valid/ready   request handshake; in_op 00 FEQ, 01 FLT, 10 FLE, 11 reserved
//   in_x1, in_x2     IEEE-754 single operands
//   in_tag           destination tag, returned unchanged on out_tag
//   out_valid/ready  result handshake toward integer writeback
//   out_result       1-bit compare result
//   out_nv           invalid-operation flag
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv
);

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    // Stage 1: captured request
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_x1_q, s1_x1_d;
    logic [31:0]      s1_x2_q, s1_x2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage 2: the output registers themselves
    logic             out_valid_q, out_valid_d;
    logic             out_result_q, out_result_d;
    logic             out_nv_q, out_nv_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic s2_load, s1_load, accept;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load && !flush;

    // Classification and compare on the stage-1 registers
    logic        x1_nan, x2_nan, x1_snan, x2_snan;
    logic        both_zero, eq, lt;
    logic [30:0] mag1, mag2;
    logic        res_c, nv_c;

    assign mag1    = s1_x1_q[30:0];
    assign mag2    = s1_x2_q[30:0];
    assign x1_nan  = (s1_x1_q[30:23] == 8'hFF) && (s1_x1_q[22:0] != 23'd0);
    assign x2_nan  = (s1_x2_q[30:23] == 8'hFF) && (s1_x2_q[22:0] != 23'd0);
    assign x1_snan = x1_nan && !s1_x1_q[22];
    assign x2_snan = x2_nan && !s1_x2_q[22];

    assign both_zero = (mag1 == 31'd0) && (mag2 == 31'd0);
    assign eq        = (s1_x1_q == s1_x2_q) || both_zero;

    always_comb begin
        lt = 1'b0;
        if (s1_x1_q[31] != s1_x2_q[31]) begin
            // -0 < +0 must stay false
            lt = s1_x1_q[31] && !both_zero;
        end else if (!s1_x1_q[31]) begin
            lt = mag1 < mag2;
        end else begin
            // Sign-magnitude: a larger magnitude is the smaller negative value
            lt = mag1 > mag2;
        end
    end

    always_comb begin
        res_c = 1'b0;
        nv_c  = 1'b0;
        case (s1_op_q)
            OP_FEQ: begin
                res_c = eq;
                nv_c  = x1_snan || x2_snan;
            end
            OP_FLT: begin
                res_c = lt;
                nv_c  = x1_nan || x2_nan;
            end
            OP_FLE: begin
                res_c = lt || eq;
                nv_c  = x1_nan || x2_nan;
            end
            default: begin
                res_c = 1'b0;
                nv_c  = 1'b0;
            end
        endcase
        if (x1_nan || x2_nan) begin
            res_c = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_x1_d      = s1_x1_q;
        s1_x2_d      = s1_x2_q;
        s1_tag_d     = s1_tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_nv_d     = out_nv_q;
        out_tag_d    = out_tag_q;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d  = in_op;
                s1_x1_d  = in_x1;
                s1_x2_d  = in_x2;
                s1_tag_d = in_tag;
            end
        end

        // Data only moves with a real request, so a bubble leaves the last
        // result visible but marked invalid.
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = res_c;
                out_nv_d     = nv_c;
                out_tag_d    = s1_tag_q;
            end
        end

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_nv_q     <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_x1_q      <= s1_x1_d;
            s1_x2_q      <= s1_x2_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_nv_q     <= out_nv_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_nv     = out_nv_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fcmp_unit.sv
// tb/tb_fcmp_unit.sv - randomized scoreboard bench for fcmp_unit
module tb_fcmp_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        out_result, out_nv;
    logic [1:0]  in_op;
    logic [31:0] in_x1, in_x2;
    logic [4:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    fcmp_unit #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_nv(out_nv)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
    } req_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: operands converted to real numbers, compared arithmetically
    function automatic real to_real(input logic [31:0] x);
        real v;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = real'(x[22:0]) * (2.0 ** -149.0);
        else             v = (real'(x[22:0]) + 8388608.0) * (2.0 ** real'(e - 150));
        return x[31] ? -v : v;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // returns {result, nv}
    function automatic logic [1:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        real va, vb;
        logic sn;
        if (op == 2'b11) return 2'b00;
        if (is_nan(a) || is_nan(b)) begin
            sn = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
            return {1'b0, (op == 2'b00) ? sn : 1'b1};
        end
        va = to_real(a);
        vb = to_real(b);
        case (op)
            2'b00:   return {va == vb, 1'b0};
            2'b01:   return {va <  vb, 1'b0};
            default: return {va <= vb, 1'b0};
        endcase
    endfunction

    // Scoreboard: one entry per accepted request still in flight
    logic [6:0]  exp_q[$];
    logic [6:0]  e;
    logic [7:0]  snap;
    bit          hold = 0;
    bit          started = 0;

    always @(negedge clk) begin
        if (started) begin
            if (rst || flush) begin
                exp_q.delete();
                hold = 0;
            end else begin
                if (hold)
                    chk("stall_stable", 64'({out_valid, out_result, out_nv, out_tag}), 64'(snap));
                chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_nv_tag", 64'({out_result, out_nv, out_tag}), 64'(e));
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back({model(in_op, in_x1, in_x2), in_tag});
                hold = out_valid && !out_ready;
                snap = {out_valid, out_result, out_nv, out_tag};
            end
        end
    end

    int         rdy_mode = 0;
    int         pidx = 0;
    logic [7:0] rdy_pat = 8'b1110_1001; // bit i = out_ready of cycle i: 1,0,0,1,0,1,1,1

    task automatic step(input bit v, input bit fl, input bit rs, input req_t r, output bit acc);
        @(posedge clk);
        #1;
        in_valid = v;
        flush    = fl;
        rst      = rs;
        in_op    = r.op;
        in_x1    = r.a;
        in_x2    = r.b;
        in_tag   = r.tag;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = (pidx < 8) ? rdy_pat[pidx] : 1'b1; pidx++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        acc = v && in_ready && !fl && !rs;
    endtask

    task automatic push_req(input req_t r);
        bit acc;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) step(1, 0, 0, r, acc);
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, acc);
    endtask

    // Drained pipe: result must be visible only after the second edge
    task automatic single(input req_t r);
        bit acc;
        step(1, 0, 0, r, acc);
        if (!acc) chk("single_accept", 64'(acc), 64'(1));
        step(0, 0, 0, '0, acc);
        chk("lat_edge_n", 64'(out_valid), 64'(0));
        step(0, 0, 0, '0, acc);
        chk("lat_edge_n1", 64'(out_valid), 64'(1));
        idle(1);
    endtask

    function automatic req_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] tag);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.tag = tag;
        return r;
    endfunction

    req_t        dir[$];
    req_t        r;
    bit          acc;
    int          l;
    logic [22:0] lm, ma;
    logic [7:0]  ea;

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_op = 0; in_x1 = 0; in_x2 = 0; in_tag = 0;
        for (int k = 0; k < 3; k++) step(0, 0, 1, '0, acc);
        started = 1;
        step(0, 0, 0, '0, acc);
        chk("reset_out", 64'({out_valid, out_result, out_nv, out_tag}), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));

        single(mk(2'b01, 32'h3F800000, 32'h40000000, 5'd21));

        dir.push_back(mk(2'b10, 32'h40000000, 32'h3F800000, 5'd1));
        dir.push_back(mk(2'b00, 32'h3F800000, 32'h3F800000, 5'd2));
        dir.push_back(mk(2'b01, 32'h80000000, 32'h00000000, 5'd3));
        dir.push_back(mk(2'b10, 32'h80000000, 32'h00000000, 5'd4));
        dir.push_back(mk(2'b00, 32'h80000000, 32'h00000000, 5'd5));
        dir.push_back(mk(2'b01, 32'hBF800000, 32'hC0000000, 5'd6));
        dir.push_back(mk(2'b01, 32'hC0000000, 32'hBF800000, 5'd7));
        dir.push_back(mk(2'b01, 32'h00000001, 32'h00000000, 5'd8));
        dir.push_back(mk(2'b01, 32'h00000000, 32'h00000001, 5'd9));
        dir.push_back(mk(2'b00, 32'h7FC00000, 32'h3F800000, 5'd10));
        dir.push_back(mk(2'b00, 32'h7F800001, 32'h3F800000, 5'd11));
        dir.push_back(mk(2'b01, 32'h7FC00000, 32'h3F800000, 5'd12));
        dir.push_back(mk(2'b10, 32'h7F800000, 32'h7F800000, 5'd13));
        dir.push_back(mk(2'b11, 32'h7F800001, 32'h3F800000, 5'd14));
        dir.push_back(mk(2'b10, 32'hFF7FFFFF, 32'h7F800000, 5'd15));
        foreach (dir[i]) push_req(dir[i]);
        idle(4);

        // Backpressure stream, tags 0..7
        rdy_mode = 1;
        pidx = 0;
        for (int t = 0; t < 8; t++)
            push_req(mk(2'($urandom_range(0, 2)), $urandom, $urandom, 5'(t)));
        rdy_mode = 0;
        idle(4);
        chk("bp_drain", 64'(exp_q.size()), 64'(0));

        // Flush with two in flight and a concurrent request
        push_req(mk(2'b01, 32'h3F800000, 32'h40000000, 5'd16));
        push_req(mk(2'b00, 32'h3F800000, 32'h3F800000, 5'd17));
        step(1, 1, 0, mk(2'b10, 32'h3F800000, 32'h3F800000, 5'd18), acc);
        step(0, 0, 0, '0, acc);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        step(0, 0, 0, '0, acc);
        chk("flush_out_valid2", 64'(out_valid), 64'(0));
        single(mk(2'b01, 32'hC0000000, 32'hBF800000, 5'd19));

        // Same with reset
        push_req(mk(2'b01, 32'h3F800000, 32'h40000000, 5'd22));
        push_req(mk(2'b00, 32'h3F800000, 32'h3F800000, 5'd23));
        step(1, 0, 1, mk(2'b10, 32'h3F800000, 32'h3F800000, 5'd24), acc);
        step(0, 0, 0, '0, acc);
        chk("rst_outputs", 64'({out_valid, out_result, out_nv, out_tag}), 64'(0));
        step(0, 0, 0, '0, acc);
        chk("rst_out_valid2", 64'(out_valid), 64'(0));
        single(mk(2'b10, 32'h00000001, 32'h80000000, 5'd25));

        // Random regression with random backpressure
        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            r.op  = 2'($urandom_range(0, 2));
            r.tag = 5'(n);
            ea    = 8'($urandom_range(0, 254));
            r.a   = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
            if (n % 2 == 0) begin
                r.b = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
            end else begin
                l  = $urandom_range(0, 23);
                lm = 23'((32'h1 << l) - 1);
                ma = r.a[22:0];
                r.b = {($urandom_range(0, 3) == 0) ? ~r.a[31] : r.a[31], ea,
                       (ma & ~lm) | (23'($urandom) & lm)};
                if (n % 7 == 1) r.b = r.a;
            end
            push_req(r);
        end
        rdy_mode = 0;
        idle(5);
        chk("final_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
